complex_mac_ctrl: RTL

//  Sequential complex-multiply controller and datapath that feeds the two 20-bit

---
 rtl/complex_mac_ctrl_if.sv | 33 +++
 rtl/complex_mac_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/complex_mac_ctrl_if.sv
// Bundle between the complex-multiply controller and its sequencer/accumulators.
// Latency: none, wires only.
// Backpressure: none; start/done is a request/pulse handshake.
interface complex_mac_ctrl_if #(
  parameter int IN_W  = 10,
  parameter int ACC_W = 20
);
  logic             start;
  logic [IN_W-1:0]  ar;
  logic [IN_W-1:0]  ai;
  logic [IN_W-1:0]  br;
  logic [IN_W-1:0]  bi;
  logic [ACC_W-1:0] re_q;
  logic [ACC_W-1:0] im_q;
  logic [ACC_W-1:0] acc_d;
  logic             acc_init;
  logic             re_en;
  logic             im_en;
  logic             busy;
  logic             done;

  // Sequencer plus accumulator side
  modport master (
    output start, ar, ai, br, bi, re_q, im_q,
    input  acc_d, acc_init, re_en, im_en, busy, done
  );

  // Controller side
  modport slave (
    input  start, ar, ai, br, bi, re_q, im_q,
    output acc_d, acc_init, re_en, im_en, busy, done
  );
endinterface

// File: rtl/complex_mac_ctrl.sv
// Four-cycle shared-multiplier complex MAC controller driving two init/en accumulators.
// Latency: start accepted at edge 0, done pulse in cycle 6, next start in cycle 7.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module complex_mac_ctrl #(
  parameter int IN_W  = 10,
  parameter int ACC_W = 20   // must be >= 2*IN_W so a full product fits before accumulation
) (
  input  logic               clk,
  input  logic               rst,
  complex_mac_ctrl_if.slave  mac_if
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_P0   = 3'd2,
    S_P1   = 3'd3,
    S_P2   = 3'd4,
    S_P3   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic signed [IN_W-1:0]   ar_q, ai_q, br_q, bi_q;
  logic signed [2*IN_W-1:0] mul_a, mul_b, prod;
  logic        [ACC_W-1:0]  prod_ext;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on an accepted start; later input changes are ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bi_q <= '0;
    end else if (state_q == S_IDLE && mac_if.start) begin
      ar_q <= mac_if.ar;
      ai_q <= mac_if.ai;
      br_q <= mac_if.br;
      bi_q <= mac_if.bi;
    end
  end

  // Next-state: fixed walk IDLE->INIT->P0..P3->DONE->IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = mac_if.start ? S_INIT : S_IDLE;
      S_INIT:  state_d = S_P0;
      S_P0:    state_d = S_P1;
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand steering into the single shared multiplier, one partial product per phase
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_P0: begin
        mul_a = (2*IN_W)'(ar_q);
        mul_b = (2*IN_W)'(br_q);
      end
      S_P1: begin
        mul_a = (2*IN_W)'(ai_q);
        mul_b = (2*IN_W)'(bi_q);
      end
      S_P2: begin
        mul_a = (2*IN_W)'(ar_q);
        mul_b = (2*IN_W)'(bi_q);
      end
      S_P3: begin
        mul_a = (2*IN_W)'(ai_q);
        mul_b = (2*IN_W)'(br_q);
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // Operands are pre-sign-extended, so the low 2*IN_W bits are the exact signed product
  assign prod     = mul_a * mul_b;
  assign prod_ext = ACC_W'(prod);

  // Moore outputs; acc_d folds the registered accumulator q with the current product
  always_comb begin
    mac_if.acc_d    = '0;
    mac_if.acc_init = 1'b0;
    mac_if.re_en    = 1'b0;
    mac_if.im_en    = 1'b0;
    mac_if.busy     = (state_q != S_IDLE);
    mac_if.done     = 1'b0;
    unique case (state_q)
      S_INIT: mac_if.acc_init = 1'b1;
      S_P0: begin
        mac_if.re_en = 1'b1;
        mac_if.acc_d = mac_if.re_q + prod_ext;
      end
      S_P1: begin
        mac_if.re_en = 1'b1;
        mac_if.acc_d = mac_if.re_q - prod_ext;
      end
      S_P2: begin
        mac_if.im_en = 1'b1;
        mac_if.acc_d = mac_if.im_q + prod_ext;
      end
      S_P3: begin
        mac_if.im_en = 1'b1;
        mac_if.acc_d = mac_if.im_q + prod_ext;
      end
      S_DONE:  mac_if.done = 1'b1;
      default: mac_if.done = 1'b0;
    endcase
  end

endmodule
